// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states and parity modes.
// Also used by the parametrised transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

endpackage

// File: rtl/uart_rx_param_if.sv
// Byte-side bus between the UART receiver and its consumer.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    // rdy is the valid flag for rx_data and the error bits. The consumer
    // acknowledges with a one-clk clr_rdy pulse. The receiver never waits:
    // a new byte overwrites rx_data and flags overrun_err if rdy was still up.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;
    logic                 clr_rdy;

    modport master (
        output rx_data, rdy, parity_err, frame_err, overrun_err, busy,
        input  clr_rdy
    );

    modport slave (
        input  rx_data, rdy, parity_err, frame_err, overrun_err, busy,
        output clr_rdy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_a,
    output logic rx_s
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx_a;
            rx_s <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable width, stop bits and errors.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RX,
    input  logic            os_tick,
    input  logic [1:0]      parity_mode,
    input  logic            two_stop,
    uart_rx_param_if.master bus,
    output rx_state_t       dbg_state
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    rx_state_t            state, next_state;
    logic                 rx_s, armed;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt, stop_last;
    logic [DATA_BITS-1:0] shreg, rx_data_q;
    logic                 two_stop_q, fe_pend, frame_err_q, rdy_q, overrun_q;
    logic                 os_clr, os_inc, bit_clr, bit_inc, shift_en;
    logic                 stop_chk, done, start_frame, at_mid, at_last;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_a  (RX),
        .rx_s  (rx_s)
    );

    assign at_mid    = os_tick && (os_cnt == OS_MID);
    assign at_last   = os_tick && (os_cnt == OS_LAST);
    // bit_cnt is reused to count stop samples
    assign stop_last = two_stop_q ? BC_W'(1) : '0;

`ifdef UART_RX_PARITY_EN
    logic [1:0] mode_q;
    logic       par_pend, par_chk, par_active, par_exp, parity_err_q;

    assign par_active = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
    assign par_exp    = (mode_q == PAR_ODD) ? ~(^shreg) : (^shreg);
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        os_clr      = 1'b0;
        os_inc      = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        shift_en    = 1'b0;
        stop_chk    = 1'b0;
        done        = 1'b0;
        start_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    next_state  = START;
                    os_clr      = 1'b1;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (at_mid) begin
                    os_clr     = 1'b1;
                    bit_clr    = 1'b1;
                    next_state = rx_s ? IDLE : DATA;
                end else if (os_tick) begin
                    os_inc = 1'b1;
                end
            end
            DATA: begin
                if (at_last) begin
                    os_clr   = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = 1'b1;
                    if (bit_cnt == BC_LAST) begin
                        bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
                        next_state = par_active ? PARITY : STOP;
`else
                        next_state = STOP;
`endif
                    end
                end else if (os_tick) begin
                    os_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_last) begin
                    os_clr     = 1'b1;
                    par_chk    = 1'b1;
                    next_state = STOP;
                end else if (os_tick) begin
                    os_inc = 1'b1;
                end
            end
`endif
            STOP: begin
                if (at_last) begin
                    os_clr   = 1'b1;
                    stop_chk = 1'b1;
                    bit_inc  = 1'b1;
                    if (bit_cnt == stop_last) begin
                        done       = 1'b1;
                        next_state = IDLE;
                    end
                end else if (os_tick) begin
                    os_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            two_stop_q  <= 1'b0;
            fe_pend     <= 1'b0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            rdy_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Re-arm only on a high line so a held break cannot retrigger
            if (state == IDLE && rx_s) armed <= 1'b1;
            else if (start_frame)      armed <= 1'b0;

            if (os_clr)      os_cnt <= '0;
            else if (os_inc) os_cnt <= os_cnt + 1'b1;

            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            if (start_frame) begin
                two_stop_q <= two_stop;
                fe_pend    <= 1'b0;
            end
            if (stop_chk && !rx_s) fe_pend <= 1'b1;

            // Completion wins over a coincident clr_rdy, which then only
            // suppresses the overrun update.
            if (done) begin
                rx_data_q   <= shreg;
                frame_err_q <= fe_pend | ~rx_s;
                rdy_q       <= 1'b1;
                if (!bus.clr_rdy) overrun_q <= overrun_q | rdy_q;
            end else if (bus.clr_rdy) begin
                rdy_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 2'd0;
            par_pend     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (start_frame) begin
                mode_q   <= parity_mode;
                par_pend <= 1'b0;
            end
            if (par_chk && (rx_s != par_exp)) par_pend <= 1'b1;
            if (done) parity_err_q <= par_pend;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data     = rx_data_q;
    assign bus.rdy         = rdy_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_q;
    assign bus.busy        = (state != IDLE);
    assign dbg_state       = state;
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the minilab serial path. Replaces the fixed 8N1 receiver with a configurable data width, runtime parity and stop-bit selection, 16x-style oversampled mid-bit sampling with false-start rejection, and per-byte error reporting. It sits between the board RX pin and the byte consumer (SPART/command logic). It is driven by the shared baud generator's oversample tick rather than a 1x baud enable.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, os_tick pulses per bit period, even, legal 8..32

Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  asynchronous serial input, idle high
- os_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none)
- two_stop  in  1  1 = check two stop bits
- clr_rdy  in  1  clears rdy and overrun_err
- rx_data  out  DATA_BITS  last received byte, LSB first on the wire
- rdy  out  1  byte available, held until clr_rdy or next byte
- parity_err  out  1  parity mismatch on the byte in rx_data
- frame_err  out  1  a stop bit sampled low on the byte in rx_data
- overrun_err  out  1  sticky: byte completed while rdy was still high
- busy  out  1  high in every state except IDLE

## Operation
- RX is double-flopped (reset value 1) before any use; rx_s is the synchronised value.
- States: IDLE, START, DATA, PARITY, STOP. os_cnt is $clog2(OVERSAMPLE) bits wide; bit_cnt is $clog2(DATA_BITS+1) bits wide.
- IDLE: armed only after rx_s has been seen high (blocks a held break line from retriggering). When armed and rx_s==0, go to START and clear os_cnt.
- START: os_cnt increments per os_tick. At os_tick with os_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s:
  - 0: go to DATA, clear os_cnt and bit_cnt.
  - 1: false start; return to IDLE with no output change.
- DATA: sample at os_tick with os_cnt==OVERSAMPLE-1, then wrap os_cnt. Shift right into the data register (MSB in) and increment bit_cnt. After the DATA_BITS-th sample go to PARITY if parity is active, else go to STOP.
- PARITY: one sample. Expected value = XOR(data) for even, ~XOR(data) for odd. A mismatch latches a pending parity error.
- STOP: one sample, or two when two_stop=1. Any low sample latches a pending framing error. At the final stop sample:
  - rx_data, parity_err and frame_err load together.
  - rdy sets.
  - overrun_err sets if rdy was already 1.
  - Return to IDLE (arm requires rx_s high, so a low stop does not restart).
- rx_data, parity_err and frame_err are updated only on frame completion. A byte with errors still asserts rdy.
- parity_mode and two_stop are sampled on the IDLE->START transition and held for the whole frame.

## Timing
- Reset values: rx_data 0, rdy 0, parity_err 0, frame_err 0, overrun_err 0, busy 0. The FSM resets to IDLE (disarmed until rx_s high). All flops use async reset, including the counters.
- RX to rx_s latency: 2 clk. rdy rises 1 clk after the os_tick of the final stop sample.
- Frame length is 1+DATA_BITS+P+S bit periods. Completion at mid stop bit leaves a half bit of margin for the next start edge.
- Simultaneous clr_rdy and frame completion: completion wins. rdy=1; overrun_err = its prior value (clr not applied).
- clr_rdy alone: rdy=0 and overrun_err=0 next clk. It does not affect parity_err or frame_err.
- os_tick absent: the FSM holds state indefinitely.
- rst_n mid-frame: immediate return to reset values. The partial byte is discarded.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state, parity check and parity_mode are functional.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_mode is kept as a port and ignored.
  - parity_err is tied 0.

## Structure
- uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP) and parity_t enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2). Shared with the future parametrised transmitter.
- Sub-module uart_rx_sync: 2-flop synchroniser, reset to 1, output rx_s. Reused by other async inputs.

## Test plan
- DATA_BITS=8, OVERSAMPLE=16, even parity, 1 stop, send 0xA5 -> rdy=1, rx_data=0xA5, parity_err=0, frame_err=0, busy=0 after the stop bit.
- Odd parity, send 0x3C with a wrong parity bit -> rdy=1, rx_data=0x3C, parity_err=1. Next good byte 0x01 clears parity_err.
- RX low pulse of 4 os_ticks, then high -> returns to IDLE, rdy stays 0, rx_data unchanged.
- two_stop=1, second stop bit driven low, send 0x55 -> rdy=1, rx_data=0x55, frame_err=1. No new frame starts until RX returns high.
- Two bytes 0x11, 0x22 without clr_rdy -> rx_data=0x22, overrun_err=1. Then clr_rdy -> rdy=0, overrun_err=0.
- Assert rst_n low in the middle of DATA bit 4, then release and send 0x7E -> all outputs 0 during reset. Next frame yields rx_data=0x7E cleanly.
